// File: rtl/encrypter_pkg.sv
// Shared configuration and types for the parallelizer / encrypter / collector path.
package encrypter_pkg;

    localparam int NUM_ENCRYPTERS  = 4;
    localparam int ENCRYPTER_WIDTH = 32;
    localparam int NIBBLES         = ENCRYPTER_WIDTH / 4;
    localparam int IDX_W           = (NUM_ENCRYPTERS > 1) ? $clog2(NUM_ENCRYPTERS) : 1;
    localparam int NIB_CNT_W       = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_ENCRYPTERS - 1);
    localparam logic [NIB_CNT_W-1:0] LAST_NIB = NIB_CNT_W'(NIBBLES - 1);

    typedef logic [ENCRYPTER_WIDTH-1:0] block_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } coll_state_e;

    // Round-robin successor of an encrypter index (wraps at the last encrypter).
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == LAST_IDX) begin
            nxt = '0;
        end else begin
            nxt = idx + IDX_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/encrypter_collector_serializer.sv
// Nibble serializer: shifts a loaded block out LSB nibble first over a
// valid/ready handshake, flags the final nibble and pulses done when it is taken.
module nibble_serializer
    import encrypter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       srst_i,
    input  logic       load_i,
    input  block_t     load_data_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [3:0] data_o,
    output logic       last_o,
    output logic       done_o
);

    block_t                 shifter_q, shifter_d;
    logic [NIB_CNT_W-1:0]   nib_cnt_q, nib_cnt_d;
    logic                   valid_q, valid_d;
    logic                   fire_s;
    logic                   at_last_s;

    assign at_last_s = (nib_cnt_q == LAST_NIB);
    assign fire_s    = valid_q & ready_i;
    assign done_o    = fire_s & at_last_s;
    assign valid_o   = valid_q;
    assign data_o    = shifter_q[3:0];
    assign last_o    = valid_q & at_last_s;

    // Next-state for shifter, nibble counter and valid; a load wins over a shift
    // so a back-to-back block replaces the one whose last nibble just left.
    always_comb begin
        shifter_d = shifter_q;
        nib_cnt_d = nib_cnt_q;
        valid_d   = valid_q;
        if (srst_i) begin
            shifter_d = '0;
            nib_cnt_d = '0;
            valid_d   = 1'b0;
        end else if (load_i) begin
            shifter_d = load_data_i;
            nib_cnt_d = '0;
            valid_d   = 1'b1;
        end else if (fire_s) begin
            shifter_d = {4'h0, shifter_q[ENCRYPTER_WIDTH-1:4]};
            if (at_last_s) begin
                nib_cnt_d = '0;
                valid_d   = 1'b0;
            end else begin
                nib_cnt_d = nib_cnt_q + NIB_CNT_W'(1);
                valid_d   = 1'b1;
            end
        end else begin
            shifter_d = shifter_q;
            nib_cnt_d = nib_cnt_q;
            valid_d   = valid_q;
        end
    end

    // Serializer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shifter_q <= '0;
            nib_cnt_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            shifter_q <= shifter_d;
            nib_cnt_q <= nib_cnt_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: rtl/encrypter_collector.sv
// Encrypter collector: captures finished blocks into per-encrypter slots and
// re-serialises them in strict round-robin order onto a 4-bit stream.
module encrypter_collector
    import encrypter_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       seq_start,
    input  logic [NUM_ENCRYPTERS-1:0]  enc_done,
    input  logic [ENCRYPTER_WIDTH-1:0] enc_result [NUM_ENCRYPTERS],
    output logic [NUM_ENCRYPTERS-1:0]  enc_ack,
    output logic [3:0]                 qspi_out_data,
    output logic                       qspi_out_valid,
    input  logic                       qspi_out_ready,
    output logic                       qspi_out_last,
    output logic                       busy
);

    block_t                      slot_q [NUM_ENCRYPTERS];
    logic [NUM_ENCRYPTERS-1:0]   slot_full_q, slot_full_d;
    logic [NUM_ENCRYPTERS-1:0]   ack_q, ack_d;
    logic [IDX_W-1:0]            ptr_q, ptr_d;
    coll_state_e                 state_q, state_d;

    logic [NUM_ENCRYPTERS-1:0]   cap_s;
    logic [IDX_W-1:0]            ptr_nxt_s;
    logic                        load_s;
    logic                        ser_done_s;
    block_t                      load_data_s;

    // A slot captures only while empty (pre-edge) and never on a restart edge.
    assign cap_s = enc_done & ~slot_full_q & {NUM_ENCRYPTERS{~seq_start}};

    // The slot to serve next: advances only when the last nibble is taken, so
    // back-to-back loading looks at the successor slot on that same edge.
    assign ptr_nxt_s   = ser_done_s ? next_idx(ptr_q) : ptr_q;
    assign load_s      = ~seq_start & slot_full_q[ptr_nxt_s]
                         & ((state_q == IDLE) | ser_done_s);
    assign load_data_s = slot_q[ptr_nxt_s];

    assign enc_ack = ack_q;
    assign busy    = (|slot_full_q) | (state_q == SEND);

    // Slot occupancy: restart clears, capture sets, hand-off to the serializer frees.
    always_comb begin
        slot_full_d = slot_full_q;
        for (int i = 0; i < NUM_ENCRYPTERS; i++) begin
            if (seq_start) begin
                slot_full_d[i] = 1'b0;
            end else if (cap_s[i]) begin
                slot_full_d[i] = 1'b1;
            end else if (load_s && (ptr_nxt_s == IDX_W'(i))) begin
                slot_full_d[i] = 1'b0;
            end else begin
                slot_full_d[i] = slot_full_q[i];
            end
        end
    end

    // Acknowledge is a one-cycle echo of the capture.
    always_comb begin
        ack_d = '0;
        if (seq_start) begin
            ack_d = '0;
        end else begin
            ack_d = cap_s;
        end
    end

    // Round-robin pointer; restart returns it to encrypter 0.
    always_comb begin
        ptr_d = ptr_q;
        if (seq_start) begin
            ptr_d = '0;
        end else begin
            ptr_d = ptr_nxt_s;
        end
    end

    // Collector FSM: IDLE waits for the pointed slot, SEND stays while blocks chain.
    always_comb begin
        state_d = state_q;
        if (seq_start) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_s) begin
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SEND: begin
                    if (load_s) begin
                        state_d = SEND;
                    end else if (ser_done_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control registers: occupancy, acks, pointer and FSM state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_full_q <= '0;
            ack_q       <= '0;
            ptr_q       <= '0;
            state_q     <= IDLE;
        end else begin
            slot_full_q <= slot_full_d;
            ack_q       <= ack_d;
            ptr_q       <= ptr_d;
            state_q     <= state_d;
        end
    end

    // Slot payload storage, written on capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENCRYPTERS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENCRYPTERS; i++) begin
                if (cap_s[i]) begin
                    slot_q[i] <= enc_result[i];
                end
            end
        end
    end

    nibble_serializer u_ser (
        .clk         (clk),
        .reset       (reset),
        .srst_i      (seq_start),
        .load_i      (load_s),
        .load_data_i (load_data_s),
        .ready_i     (qspi_out_ready),
        .valid_o     (qspi_out_valid),
        .data_o      (qspi_out_data),
        .last_o      (qspi_out_last),
        .done_o      (ser_done_s)
    );

endmodule
